// File: rtl/stream_muxn.sv
// stream_muxn: N-input valid/ready stream multiplexer with a one-deep output
// register. The channel is chosen by an explicit select (MODE 0) or by a
// round-robin search over the valid inputs (MODE 1).
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    per-channel beat valid           [N_INPUTS]
//   in_data     flat channel data, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready    per-channel accept (combinational)
//   sel         channel select, MODE 0 only
//   out_valid   output beat valid
//   out_data    output beat data
//   out_src     channel index of the output beat
//   out_ready   downstream accept
//   err_sel     one-cycle pulse for an out-of-range select
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module stream_muxn #(
    parameter int  DATA_WIDTH = `DATA_WIDTH,
    parameter int  N_INPUTS   = 3,
    parameter int  MODE       = 0,
    localparam int SEL_WIDTH  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic [N_INPUTS-1:0]            in_ready,
    input  logic [SEL_WIDTH-1:0]           sel,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]           out_src,
    input  logic                           out_ready,
    output logic                           err_sel
);

    // One extra bit so rr_ptr + offset never overflows before the modulo.
    localparam int                  IW   = SEL_WIDTH + 1;
    localparam logic [SEL_WIDTH:0]  NUM  = IW'(N_INPUTS);
    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(N_INPUTS - 1);

    logic                                 r_out_valid;
    logic [DATA_WIDTH-1:0]                r_out_data;
    logic [SEL_WIDTH-1:0]                 r_out_src;
    logic [SEL_WIDTH-1:0]                 r_rr_ptr;
    logic                                 r_err_sel;

    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  w_chan;
    logic                                 w_load;
    logic                                 w_sel_ok;
    logic                                 w_gnt_vld;
    logic [SEL_WIDTH-1:0]                 w_gnt;
    logic [SEL_WIDTH:0]                   w_idx;
    logic                                 w_hit;
    logic                                 w_xfer;

    assign w_chan = in_data;
    assign w_load = !r_out_valid || out_ready;

    // Grant selection. A single channel is always granted; MODE 1 scans
    // rr_ptr, rr_ptr+1, ... and takes the first valid channel.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        w_sel_ok  = ({1'b0, sel} < NUM);
        if (N_INPUTS == 1) begin
            w_gnt_vld = 1'b1;
        end else if (MODE == 0) begin
            w_gnt_vld = w_sel_ok;
            w_gnt     = w_sel_ok ? sel : '0;
        end else begin
            for (int k = 0; k < N_INPUTS; k++) begin
                w_idx = {1'b0, r_rr_ptr} + IW'(k);
                if (w_idx >= NUM)
                    w_idx = w_idx - NUM;
                if (!w_gnt_vld && in_valid[w_idx[SEL_WIDTH-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = w_idx[SEL_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        if (w_gnt_vld)
            w_hit = in_valid[w_gnt];
    end

    assign w_xfer = w_load && w_hit;

    // Ready is forced low during reset since load is otherwise true there.
    always_comb begin
        in_ready = '0;
        if (rst_n && w_load && w_gnt_vld)
            in_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
            r_err_sel   <= 1'b0;
        end else begin
            // data/src hold when the slot empties; only valid drops
            if (w_load) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_chan[w_gnt];
                    r_out_src  <= w_gnt;
                end
            end
            if (MODE == 1 && w_xfer)
                r_rr_ptr <= (w_gnt == LAST) ? '0 : w_gnt + SEL_WIDTH'(1);
            r_err_sel <= (MODE == 0) && (N_INPUTS > 1) && w_load &&
                         (|in_valid) && !w_sel_ok;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_stream_muxn.sv
// Bench for stream_muxn: one MODE 0 and one MODE 1 instance (3 x 32-bit)
// driven with the same inputs. A per-instance model predicts grants and
// pushes expected beats; a negedge monitor pops and compares them.
module tb_stream_muxn;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        iv;
    logic [95:0]       din;
    logic [1:0]        sel;
    logic              ordy;

    logic [1:0]        ov;
    logic [1:0][31:0]  od;
    logic [1:0][1:0]   os;
    logic [1:0][2:0]   irdy;
    logic [1:0]        err;

    int checks = 0;
    int errors = 0;

    // model state per instance
    bit         m_ov  [2];
    bit         m_err [2];
    int         m_rr  [2];
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    bit          seen [2];
    logic [33:0] held [2];

    localparam logic [31:0] A = 32'h0000AAAA;
    localparam logic [31:0] B = 32'h0000BBBB;
    localparam logic [31:0] C = 32'h0000CCCC;

    always #5 clk = ~clk;

    stream_muxn #(.DATA_WIDTH(32), .N_INPUTS(3), .MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(din),
        .in_ready(irdy[0]), .sel(sel), .out_valid(ov[0]), .out_data(od[0]),
        .out_src(os[0]), .out_ready(ordy), .err_sel(err[0]));

    stream_muxn #(.DATA_WIDTH(32), .N_INPUTS(3), .MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(din),
        .in_ready(irdy[1]), .sel(sel), .out_valid(ov[1]), .out_data(od[1]),
        .out_src(os[1]), .out_ready(ordy), .err_sel(err[1]));

    task automatic chk(input string nm, input int m, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, m, act, exp, $time);
        end
    endtask

    // Grant per the selection rules: explicit sel, or first valid channel
    // in rotated order starting at the round-robin pointer.
    function automatic void model_grant(input int m, input logic [2:0] v,
                                        input int s, input int rr,
                                        output bit gv, output int g);
        int c;
        gv = 1'b0;
        g  = 0;
        if (m == 0) begin
            if (s < 3) begin gv = 1'b1; g = s; end
        end else begin
            for (int k = 0; k < 3; k++) begin
                c = (rr + k) % 3;
                if (!gv && v[c]) begin gv = 1'b1; g = c; end
            end
        end
    endfunction

    // One clock cycle: check registered state, drive inputs, check ready,
    // then advance the model to what the next edge should produce.
    task automatic step(input logic [2:0] v, input logic [95:0] d,
                        input logic [1:0] s, input logic r);
        bit load, gv, x;
        int g;
        logic [2:0]  er;
        logic [33:0] bt;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("out_valid", m, 64'(ov[m]), 64'(m_ov[m]));
            chk("err_sel",   m, 64'(err[m]), 64'(m_err[m]));
        end
        #1;
        iv = v; din = d; sel = s; ordy = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            load = !m_ov[m] || r;
            model_grant(m, v, int'(s), m_rr[m], gv, g);
            er = (load && gv) ? 3'(1 << g) : 3'b000;
            chk("in_ready", m, 64'(irdy[m]), 64'(er));
            x = load && gv && v[g];
            m_err[m] = (m == 0) && load && (|v) && !gv;
            if (x) begin
                bt = {d[g*32 +: 32], 2'(g)};
                if (m == 0) q0.push_back(bt); else q1.push_back(bt);
                m_rr[m] = (g + 1) % 3;
            end
            if (load) m_ov[m] = x;
        end
    endtask

    // Monitor: a newly presented beat is popped and compared; while it
    // waits for out_ready it must stay identical.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                if (ov[m]) begin
                    if (!seen[m]) begin
                        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_beat dut%0d got %0h/%0d expected none", m, od[m], os[m]);
                        end else begin
                            e = (m == 0) ? q0.pop_front() : q1.pop_front();
                            chk("out_data", m, 64'(od[m]), 64'(e[33:2]));
                            chk("out_src",  m, 64'(os[m]), 64'(e[1:0]));
                            held[m] = e;
                        end
                        seen[m] = 1'b1;
                    end else begin
                        chk("hold_beat", m, 64'({od[m], os[m]}), 64'(held[m]));
                    end
                    if (ordy) seen[m] = 1'b0;
                end
            end
        end
    end

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ov[m] = 1'b0; m_err[m] = 1'b0; m_rr[m] = 0;
            seen[m] = 1'b0; held[m] = '0;
        end
        q0.delete(); q1.delete();
    endtask

    initial begin
        logic [95:0] abc;
        abc = {C, B, A};
        rst_n = 1'b0; iv = '0; din = '0; sel = '0; ordy = 1'b1;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid", m, 64'(ov[m]), 64'd0);
            chk("rst_in_ready",  m, 64'(irdy[m]), 64'd0);
            chk("rst_err_sel",   m, 64'(err[m]), 64'd0);
            chk("rst_out_data",  m, 64'(od[m]), 64'd0);
        end
        #20 rst_n = 1'b1;

        // explicit select of channel 1, then an out-of-range select
        step(3'b111, abc, 2'd1, 1'b1);
        chk("sel1_ready", 0, 64'(irdy[0]), 64'(3'b010));
        step(3'b111, abc, 2'd3, 1'b1);
        chk("sel3_ready", 0, 64'(irdy[0]), 64'(3'b000));
        step(3'b000, abc, 2'd0, 1'b1);

        // stall with B held, then change sel and B's data
        step(3'b111, abc, 2'd1, 1'b0);
        step(3'b111, {C, 32'h12345678, A}, 2'd2, 1'b0);
        chk("stall_ready", 0, 64'(irdy[0]), 64'(3'b000));
        step(3'b111, {C, 32'h12345678, A}, 2'd2, 1'b0);
        step(3'b111, {C, 32'h12345678, A}, 2'd2, 1'b1);
        step(3'b000, abc, 2'd0, 1'b1);

        // round-robin with all valid, then with channel 1 idle
        for (int i = 0; i < 6; i++) step(3'b111, abc, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b101, abc, 2'd1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // reset in the middle of a stall with C held
        step(3'b000, abc, 2'd2, 1'b1);
        step(3'b111, abc, 2'd2, 1'b1);
        step(3'b111, abc, 2'd2, 1'b0);
        step(3'b111, abc, 2'd2, 1'b0);
        #3 rst_n = 1'b0;
        iv = 3'b000; ordy = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_out_valid", m, 64'(ov[m]), 64'd0);
            chk("midrst_in_ready",  m, 64'(irdy[m]), 64'd0);
            chk("midrst_out_src",   m, 64'(os[m]), 64'd0);
        end
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(3'b111, abc, 2'd0, 1'b1);

        // drain
        for (int i = 0; i < 3; i++) step(3'b000, abc, 2'd0, 1'b1);
        chk("q0_empty", 0, 64'(q0.size()), 64'd0);
        chk("q1_empty", 1, 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_muxn.md
STREAM_MUXN -- requirements
Module: stream_muxn

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default `DATA_WIDTH, width of each data channel in bits.
REQ-002 SHALL provide parameter N_INPUTS, default 3, number of input channels (legal range 1..16).
REQ-003 SHALL provide parameter MODE, default 0, selection mode: 0 = explicit sel, 1 = round-robin.
REQ-004 SHALL provide localparam SEL_WIDTH = max(1, $clog2(N_INPUTS)).
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  N_INPUTS  per-channel beat valid.
REQ-008 SHALL have port in_data  input  N_INPUTS*DATA_WIDTH  flat channel data; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_ready  output  N_INPUTS  per-channel accept.
REQ-010 SHALL have port sel  input  SEL_WIDTH  channel select, used only in MODE 0.
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  output beat data.
REQ-013 SHALL have port out_src  output  SEL_WIDTH  channel index of the current output beat.
REQ-014 SHALL have port out_ready  input  1  downstream accept.
REQ-015 SHALL have port err_sel  output  1  one-cycle pulse flagging an out-of-range select.

Function
REQ-016 SHALL define load = !out_valid || out_ready; the output register accepts a new beat only when load is 1.
REQ-017 In MODE 0, grant g SHALL equal sel when sel < N_INPUTS; for sel >= N_INPUTS no channel is granted.
REQ-018 In MODE 1, grant g SHALL be the first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... modulo N_INPUTS; if no in_valid is set, no channel is granted.
REQ-019 in_ready[i] SHALL be 1 only when load = 1, a grant exists and i == g; all other in_ready bits SHALL be 0 (combinational, may depend on in_valid in MODE 1).
REQ-020 On a transfer (in_valid[g] && in_ready[g]) the next edge SHALL set out_valid=1, out_data=in_data[g], out_src=g; latency is 1 cycle and throughput is 1 beat per cycle.
REQ-021 When load = 1 and no transfer occurs, the next edge SHALL clear out_valid; out_data and out_src SHALL hold.
REQ-022 When out_valid = 1 and out_ready = 0 (stall), out_valid, out_data and out_src SHALL hold regardless of sel, in_valid or in_data changes.
REQ-023 rr_ptr (SEL_WIDTH bits, MODE 1 only) SHALL update to (g+1) mod N_INPUTS on each transfer, wrapping from N_INPUTS-1 to 0, and SHALL hold otherwise.
REQ-024 err_sel SHALL be 1 for exactly the cycle after any edge where MODE = 0, load = 1, |in_valid = 1 and sel >= N_INPUTS; otherwise err_sel SHALL be 0.
REQ-025 With N_INPUTS = 1, grant SHALL always be channel 0 in both modes, and out_src SHALL be constant 0.
REQ-026 A simultaneous out_ready handshake and new transfer SHALL replace the output beat in the same edge with no bubble.

Reset
REQ-027 While rst_n = 0, out_valid, out_data, out_src, rr_ptr and err_sel SHALL be 0 immediately (asynchronously), and all in_ready SHALL be 0.
REQ-028 Reset asserted during a stall SHALL discard the held beat; no beat SHALL be presented after release until a new transfer.
REQ-029 The first MODE 1 grant after reset SHALL go to the lowest-index valid channel, starting the search at channel 0.

Verification (N_INPUTS=3, DATA_WIDTH=32; A=0000AAAA, B=0000BBBB, C=0000CCCC on channels 0/1/2)
REQ-030 MODE 0, sel=1, in_valid=111, out_ready=1 -> in_ready=010; next cycle out_valid=1, out_data=0000BBBB, out_src=1.
REQ-031 MODE 0, sel=3, in_valid=111 -> in_ready=000; next cycle out_valid=0 and err_sel=1 for one cycle.
REQ-032 MODE 0, beat B held with out_ready=0, then sel=2 and B changed to 12345678 -> out_data stays 0000BBBB and in_ready=000 until out_ready=1; the following beat is 0000CCCC.
REQ-033 MODE 1, in_valid=111 continuously, out_ready=1 -> out_src sequence 0,1,2,0,1 on consecutive cycles with no bubbles.
REQ-034 MODE 1, in_valid=101 -> out_src alternates 0,2,0,2; channel 1 is never granted.
REQ-035 Assert rst_n=0 mid-stall with beat C held -> out_valid=0 with no clock edge required; after release with in_valid=111 in MODE 1, the first out_src=0.
